// File: rtl/spi_ram_ctrl.sv
// ============================================================================
// Module      : spi_ram_ctrl
// Description : Single-port 8-bit RAM with a command decoder that sits behind
//               an SPI slave. Each rising edge of the level rx_valid accepts
//               one 10-bit word: din[9:8] selects write-address, write-data,
//               read-address or read-data, din[7:0] carries the payload.
//               Read bytes are returned on dout/tx_valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);

    localparam logic [1:0] c_op_wr_addr = 2'b00;
    localparam logic [1:0] c_op_wr_data = 2'b01;
    localparam logic [1:0] c_op_rd_addr = 2'b10;
    localparam logic [1:0] c_op_rd_data = 2'b11;

    // Storage array; contents deliberately survive reset.
    logic [7:0]           r_mem [MEM_DEPTH];

    logic                 r_rx_valid_q;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic [7:0]           r_dout;
    logic                 r_tx_valid;

    logic                 w_accept;
    logic [1:0]           w_op;
    logic [ADDR_SIZE-1:0] w_addr_in;

    // rx_valid is a level held for the whole word; only its rising edge
    // counts as a command, so a long hold still performs one operation.
    assign w_accept  = rx_valid & ~r_rx_valid_q;
    assign w_op      = din[9:8];
    assign w_addr_in = ADDR_SIZE'(din[7:0]);

    assign dout      = r_dout;
    assign tx_valid  = r_tx_valid;

    // Edge detector, address registers and registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_valid_q <= 1'b0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_dout       <= 8'h00;
            r_tx_valid   <= 1'b0;
        end else begin
            r_rx_valid_q <= rx_valid;
            if (w_accept) begin
                // Any accepted command retires the previous read byte; a new
                // read-data command immediately re-arms it with fresh data.
                r_tx_valid <= (w_op == c_op_rd_data);
                case (w_op)
                    c_op_wr_addr: r_wr_addr <= w_addr_in;
                    c_op_wr_data: begin
                        if (AUTO_INC) begin
                            r_wr_addr <= r_wr_addr + ADDR_SIZE'(1);
                        end
                    end
                    c_op_rd_addr: r_rd_addr <= w_addr_in;
                    c_op_rd_data: begin
                        r_dout <= r_mem[r_rd_addr];
                        if (AUTO_INC) begin
                            r_rd_addr <= r_rd_addr + ADDR_SIZE'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Array write port; kept reset-free so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_accept && (w_op == c_op_wr_data)) begin
            r_mem[r_wr_addr] <= din[7:0];
        end
    end

endmodule

`default_nettype wire
